instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/core_config_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_config_pkg : shared core widths, fetch constants and types      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_config_pkg;

    localparam int XLEN             = 32;
    localparam int IF_LEN           = 32;
    localparam int FETCH_FIFO_DEPTH = 2;

    // addi x0, x0, 0
    localparam logic [IF_LEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE    = 2'd0;
    localparam fetch_state_t ST_REQ     = 2'd1;
    localparam fetch_state_t ST_DISCARD = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [IF_LEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : core_config_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO with flush, occupancy count and flags  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch : single-outstanding fetch unit with prefetch FIFO |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_fetch
    import core_config_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int              FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              i_busy,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_addr,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [IF_LEN-1:0] mem_rdata,
    output logic [IF_LEN-1:0] instruction,
    output logic [XLEN-1:0]   o_address,
    output logic              o_valid,
    output logic              fetch_misaligned
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CA_W  = CNT_W + 1;

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_inc;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             push;
    logic             pop;
    logic             flush;
    logic             target_misaligned;
    logic [CA_W-1:0]  count_after;
    logic             slot_left;
    logic             slot_free;

    assign pc_inc            = pc + XLEN'(4);
    assign target_misaligned = !is_word_aligned(redirect_addr);

    // Redirect masks both FIFO ports; the flush wins over any same-edge ack.
    assign flush = clk_en && redirect;
    assign push  = clk_en && !redirect && (state == ST_REQ) && mem_ack;
    assign pop   = clk_en && !redirect && !i_busy && !fifo_empty;

    assign push_entry = '{addr: mem_addr, instr: mem_rdata};

    assign count_after = CA_W'(fifo_count) + CA_W'(push) - CA_W'(pop);
    assign slot_left   = (count_after < CA_W'(FIFO_DEPTH));
    assign slot_free   = (fifo_count < CNT_W'(FIFO_DEPTH));

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pc               <= RESET_ADDR;
            mem_req          <= 1'b0;
            mem_addr         <= RESET_ADDR;
            fetch_misaligned <= 1'b0;
        end else if (clk_en) begin
            if (redirect) begin
                pc               <= redirect_addr;
                fetch_misaligned <= target_misaligned;
                if (mem_req && !mem_ack) begin
                    // Bus request must complete; its data is thrown away.
                    state <= ST_DISCARD;
                end else if (target_misaligned) begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end else begin
                    state    <= ST_REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= redirect_addr;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (slot_free && !fetch_misaligned) begin
                            state    <= ST_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end
                    end
                    ST_REQ: begin
                        if (mem_ack) begin
                            pc       <= pc_inc;
                            mem_addr <= pc_inc;
                            if (slot_left) begin
                                state <= ST_REQ;
                            end else begin
                                state   <= ST_IDLE;
                                mem_req <= 1'b0;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (mem_ack) begin
                            if (fetch_misaligned) begin
                                state   <= ST_IDLE;
                                mem_req <= 1'b0;
                            end else begin
                                state    <= ST_REQ;
                                mem_addr <= pc;
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_INSTR;
            o_address   <= '0;
            o_valid     <= 1'b0;
        end else if (clk_en) begin
            if (redirect) begin
                instruction <= NOP_INSTR;
                o_valid     <= 1'b0;
            end else if (!i_busy) begin
                if (!fifo_empty) begin
                    instruction <= head.instr;
                    o_address   <= head.addr;
                    o_valid     <= 1'b1;
                end else begin
                    instruction <= NOP_INSTR;
                    o_valid     <= 1'b0;
                end
            end
        end
    end

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch : directed self-checking bench for fetch unit   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        i_busy;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic [31:0] o_address;
    logic        o_valid;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .RESET_ADDR (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .i_busy           (i_busy),
        .redirect         (redirect),
        .redirect_addr    (redirect_addr),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .instruction      (instruction),
        .o_address        (o_address),
        .o_valid          (o_valid),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    // Memory returns its own address as data
    assign mem_rdata = mem_addr;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; i_busy = 1'b0; redirect = 1'b0;
        redirect_addr = 32'h0; mem_ack = 1'b1;
        tick(); tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instruction, NOP);
        chk("rst_o_address", o_address, 32'h0);
        chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);

        // Streaming with ack tied high
        rst_n = 1'b1;
        tick();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        tick();
        chk("bubble_valid", {31'b0, o_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stream_instr", instruction, 32'(4 * k));
            chk("stream_addr", o_address, 32'(4 * k));
            chk("stream_valid", {31'b0, o_valid}, 32'd1);
        end

        // Downstream stall: hold outputs, buffer two words, stop requesting
        i_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("busy_hold_instr", instruction, 32'hC);
            chk("busy_hold_valid", {31'b0, o_valid}, 32'd1);
            chk("busy_no_req", {31'b0, mem_req}, 32'd0);
        end
        i_busy = 1'b0;
        tick();
        chk("drain0", instruction, 32'h10);
        tick();
        chk("drain1", instruction, 32'h14);
        chk("refetch_req", {31'b0, mem_req}, 32'd1);
        chk("refetch_addr", mem_addr, 32'h18);
        tick();
        chk("drain_bubble", {31'b0, o_valid}, 32'd0);
        tick();
        chk("resume_instr", instruction, 32'h18);
        chk("resume_valid", {31'b0, o_valid}, 32'd1);

        // Redirect with outstanding request to 0x8
        rst_n = 1'b0; mem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("pre_redir_instr", instruction, 32'h0);
        chk("pending_addr", mem_addr, 32'h8);
        redirect = 1'b1; redirect_addr = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir_nop", instruction, NOP);
        chk("redir_valid", {31'b0, o_valid}, 32'd0);
        chk("discard_hold_addr", mem_addr, 32'h8);
        chk("discard_hold_req", {31'b0, mem_req}, 32'd1);
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        chk("after_discard_addr", mem_addr, 32'h100);
        chk("after_discard_valid", {31'b0, o_valid}, 32'd0);
        tick();
        chk("no_stale_word", {31'b0, o_valid}, 32'd0);
        tick();
        chk("redir_target_addr", o_address, 32'h100);
        chk("redir_target_instr", instruction, 32'h100);
        chk("redir_target_valid", {31'b0, o_valid}, 32'd1);

        // Redirect on the same edge as an ack
        redirect = 1'b1; redirect_addr = 32'h40;
        tick();
        redirect = 1'b0;
        chk("same_edge_nop", instruction, NOP);
        chk("same_edge_valid", {31'b0, o_valid}, 32'd0);
        chk("same_edge_addr", mem_addr, 32'h40);
        tick();
        chk("same_edge_bubble", {31'b0, o_valid}, 32'd0);
        tick();
        chk("same_edge_next", o_address, 32'h40);

        // Misaligned redirect blocks fetch until an aligned redirect
        redirect = 1'b1; redirect_addr = 32'h102;
        tick();
        redirect = 1'b0;
        chk("misaligned_flag", {31'b0, fetch_misaligned}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("misaligned_no_req", {31'b0, mem_req}, 32'd0);
            chk("misaligned_no_valid", {31'b0, o_valid}, 32'd0);
        end
        redirect = 1'b1; redirect_addr = 32'h200;
        tick();
        redirect = 1'b0;
        chk("misaligned_clear", {31'b0, fetch_misaligned}, 32'd0);
        chk("realign_req", {31'b0, mem_req}, 32'd1);
        chk("realign_addr", mem_addr, 32'h200);
        tick();
        tick();
        chk("realign_instr", instruction, 32'h200);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap_mem_addr", mem_addr, 32'h0);
        tick();
        chk("wrap_top_addr", o_address, 32'hFFFF_FFFC);

        // Global enable low freezes everything
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("freeze_instr", instruction, 32'hFFFF_FFFC);
            chk("freeze_mem_addr", mem_addr, 32'h4);
        end
        clk_en = 1'b1;
        tick();
        chk("unfreeze_instr", instruction, 32'h0);
        chk("unfreeze_valid", {31'b0, o_valid}, 32'd1);

        // Asynchronous reset abandons an in-flight request
        chk("pre_reset_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_addr", mem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch
`default_nettype wire
